mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch port (IF stage) and the data-access port (MEM stage) of the RV32I pipeline.
- Used in the unified-memory build of the core, where separate IMEM and DMEM are replaced by one SRAM.
- Arbitrates per cycle, tracks in-flight reads in a tag pipeline, routes read data back to the owner, and generates stall requests for the hazard logic.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8.
- MEM_LATENCY, 1, cycles from accepted read to mem_rdata valid. Legal range 1..4.
- STARVE_LIMIT, 3, consecutive denied IF-request cycles before IF is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request, held until granted
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched instruction
- dm_req  in  1  data request, held until granted
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  DATA_WIDTH/8  store byte enables
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  dm_rdata valid (loads only)
- dm_rdata  out  DATA_WIDTH  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, MEM_LATENCY cycles after the read strobe
- stall_if  out  1  = if_req & ~if_gnt
- stall_mem  out  1  = (dm_req & ~dm_gnt) | load pending

Behaviour:
- Arbitration is combinational within the cycle, and at most one grant is issued per cycle.
  - Only if_req: IF wins. Only dm_req: DM wins.
  - Both requesting: DM wins unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- Memory drive:
  - mem_en = if_gnt | dm_gnt.
  - mem_addr, mem_we, mem_be and mem_wdata come from the winner.
  - An IF grant drives mem_we = 0 and mem_be = all ones.
  - With no grant: mem_en = 0, mem_we = 0, mem_be = 0; address and data are don't-care but are driven to 0.
- Starvation counter (starve_cnt, 4 bits):
  - Increments when if_req & ~if_gnt.
  - Clears to 0 when if_gnt or ~if_req.
  - Saturates at STARVE_LIMIT.
- Tag pipeline, MEM_LATENCY stages of {valid, owner}:
  - Stage 0 loads {1, IF} on an IF grant, {1, DM} on a DM grant with dm_we = 0, and {0, x} otherwise.
  - Stores never create a tag.
- Response routing:
  - At the last stage, if_rvalid = valid & owner==IF and dm_rvalid = valid & owner==DM.
  - if_rdata = dm_rdata = mem_rdata, qualified only by the respective rvalid.
- Load pending: 1 while any tag stage holds a DM read; it is included in stall_mem.
- Back-to-back requests:
  - Reads may be granted every cycle, so up to MEM_LATENCY reads can be in flight.
  - Responses return in grant order, one per cycle.
- Request held across cycles with changing address: the address is sampled only in the grant cycle.
- Reset (rst = 1 at a clock edge):
  - Tag pipeline and starve_cnt clear.
  - All in-flight responses are dropped; no rvalid follows.
  - While rst = 1, if_gnt, dm_gnt, mem_en, if_rvalid and dm_rvalid are forced to 0.
- Reset values of all outputs are 0.
- Simultaneous store grant and load response in the same cycle is legal: the response comes from the tag stage, the store from the current grant.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On a conflict, priority alternates. A last_winner flop is updated on every grant, and the requester that did not win the last grant wins.
  - starve_cnt is removed.
  - last_winner resets to IF, so DM wins the first conflict.
- Undefined: DM priority with starvation limit, as described in Behaviour.

Test Plan:
- Reset hold: rst = 1 with both requests asserted for 3 cycles -> all grants, mem_en and rvalids are 0. Release -> DM granted in the first cycle.
- Single fetch: if_req with addr 0x0000_0040, memory returns 0x0050_0093, MEM_LATENCY = 1 -> if_gnt in cycle N, mem_addr = 0x40 in N, if_rvalid with data 0x0050_0093 in N+1, dm_rvalid = 0.
- Starvation: both requests held, STARVE_LIMIT = 3 -> dm_gnt for 3 cycles, if_gnt in cycle 4, stall_if high in cycles 1-3.
- Store/load mix: store 0xDEAD_BEEF to 0x100 with be = 4'b1111, then load 0x100, MEM_LATENCY = 2 -> mem_we = 1 for one cycle with no tag; dm_rvalid 2 cycles after the load grant with 0xDEAD_BEEF; stall_mem high until dm_rvalid.
- Mid-flight reset: IF read granted, MEM_LATENCY = 3, rst pulsed in the next cycle -> no if_rvalid is ever produced for that read.
- Round-robin, MEM_ARB_ROUND_ROBIN_EN defined: both requests held 4 cycles -> grants DM, IF, DM, IF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between the IF
// (fetch) and MEM (data) ports of the RV32I pipeline.
//  - Per-cycle combinational arbitration, at most one grant per cycle.
//  - Default priority: DM wins conflicts, except that IF wins once it has been
//    denied STARVE_LIMIT consecutive cycles.
//  - Build option MEM_ARB_ROUND_ROBIN_EN: conflicts alternate between the two
//    ports through a last_winner flop, and the starvation counter is removed.
//  - A MEM_LATENCY-deep {valid, owner} tag pipeline routes read data back to
//    its requester in grant order. Stores never create a tag.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,   // 1..4
  parameter int STARVE_LIMIT = 3    // 1..15
) (
  input  logic                    clk,
  input  logic                    rst,
  // instruction fetch port
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  // data access port
  input  logic                    dm_req,
  input  logic                    dm_we,
  input  logic [DATA_WIDTH/8-1:0] dm_be,
  input  logic [ADDR_WIDTH-1:0]   dm_addr,
  input  logic [DATA_WIDTH-1:0]   dm_wdata,
  output logic                    dm_gnt,
  output logic                    dm_rvalid,
  output logic [DATA_WIDTH-1:0]   dm_rdata,
  // memory side
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  // hazard unit
  output logic                    stall_if,
  output logic                    stall_mem
);

  localparam int BE_W = DATA_WIDTH / 8;

  // Owner encoding used in the tag pipeline and the round-robin flop.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Tag pipeline: stage 0 is written at the grant edge, the last stage lines
  // up with mem_rdata.
  logic [MEM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [MEM_LATENCY-1:0] tag_own_q, tag_own_d;
  logic                   load_pend;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Winner of the most recent grant; the other port wins the next conflict.
  logic last_winner_q, last_winner_d;
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  // Consecutive cycles IF has asked and been refused.
  logic [3:0] starve_cnt_q, starve_cnt_d;
`endif

  // Arbitration: single grant per cycle, nothing granted while in reset.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (!rst) begin
      if (if_req && dm_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (last_winner_q == OWN_IF) dm_gnt = 1'b1;
        else                         if_gnt = 1'b1;
`else
        if (starve_cnt_q == STARVE_MAX) if_gnt = 1'b1;
        else                            dm_gnt = 1'b1;
`endif
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  // Memory drive: winner's request, everything zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = {BE_W{1'b1}};
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_be    = dm_be;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Remember who won the last grant; hold when nothing was granted.
  always_comb begin
    last_winner_d = last_winner_q;
    if (if_gnt)      last_winner_d = OWN_IF;
    else if (dm_gnt) last_winner_d = OWN_DM;
  end

  // Round-robin state register; resets to IF so DM takes the first conflict.
  always_ff @(posedge clk) begin
    if (rst) last_winner_q <= OWN_IF;
    else     last_winner_q <= last_winner_d;
  end
`else
  // Count refused IF cycles, saturating at the limit; any grant or a dropped
  // request starts the count over.
  always_comb begin
    starve_cnt_d = '0;
    if (if_req && !if_gnt) begin
      if (starve_cnt_q >= STARVE_MAX) starve_cnt_d = STARVE_MAX;
      else                            starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`endif

  // Tag pipeline next state: new tag for every read grant, then shift.
  always_comb begin
    tag_vld_d    = '0;
    tag_own_d    = '0;
    tag_vld_d[0] = if_gnt | (dm_gnt & ~dm_we);
    tag_own_d[0] = dm_gnt ? OWN_DM : OWN_IF;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_own_d[i] = tag_own_q[i-1];
    end
  end

  // Tag pipeline register; reset drops every in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_own_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
    end
  end

  // A DM load is in flight while any valid stage is owned by DM.
  assign load_pend = |(tag_vld_q & tag_own_q);

  // Response routing from the last tag stage; data is zeroed when not valid.
  always_comb begin
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if (!rst && tag_vld_q[MEM_LATENCY-1]) begin
      if (tag_own_q[MEM_LATENCY-1] == OWN_IF) if_rvalid = 1'b1;
      else                                    dm_rvalid = 1'b1;
    end
    if_rdata = if_rvalid ? mem_rdata : '0;
    dm_rdata = dm_rvalid ? mem_rdata : '0;
  end

  // Stall requests for the hazard unit; held low in reset so every output
  // comes up zero.
  always_comb begin
    stall_if  = 1'b0;
    stall_mem = 1'b0;
    if (!rst) begin
      stall_if  = if_req & ~if_gnt;
      stall_mem = (dm_req & ~dm_gnt) | load_pend;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Three instances share one stimulus
// stream and differ only in MEM_LATENCY (index 0/1/2 -> latency 1/2/3).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, mem_rdata;

  logic        if_gnt_w [3];
  logic        if_rvalid_w [3];
  logic [31:0] if_rdata_w [3];
  logic        dm_gnt_w [3];
  logic        dm_rvalid_w [3];
  logic [31:0] dm_rdata_w [3];
  logic        mem_en_w [3];
  logic        mem_we_w [3];
  logic [3:0]  mem_be_w [3];
  logic [31:0] mem_addr_w [3];
  logic [31:0] mem_wdata_w [3];
  logic        stall_if_w [3];
  logic        stall_mem_w [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(g + 1), .STARVE_LIMIT(3)
    ) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[g]),
      .if_rvalid(if_rvalid_w[g]), .if_rdata(if_rdata_w[g]),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(dm_gnt_w[g]),
      .dm_rvalid(dm_rvalid_w[g]), .dm_rdata(dm_rdata_w[g]),
      .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]), .mem_be(mem_be_w[g]),
      .mem_addr(mem_addr_w[g]), .mem_wdata(mem_wdata_w[g]),
      .mem_rdata(mem_rdata),
      .stall_if(stall_if_w[g]), .stall_mem(stall_mem_w[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and
  // outputs sampled 2 time units later, well clear of both edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0020;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h0000_0200;
    dm_wdata = 32'h1111_2222; mem_rdata = 32'h0;

    // Reset hold: both requesting, nothing may be granted or returned.
    for (int c = 0; c < 3; c++) begin
      tick(); #2;
      chk("rst_if_gnt",    32'(if_gnt_w[0]),    32'd0);
      chk("rst_dm_gnt",    32'(dm_gnt_w[0]),    32'd0);
      chk("rst_mem_en",    32'(mem_en_w[0]),    32'd0);
      chk("rst_if_rvalid", 32'(if_rvalid_w[0]), 32'd0);
      chk("rst_dm_rvalid", 32'(dm_rvalid_w[0]), 32'd0);
    end
    chk("rst_mem_addr", mem_addr_w[0], 32'h0);

    // Release: DM has priority in the first cycle (store, no tag).
    rst = 1'b0; #2;
    chk("rel_dm_gnt", 32'(dm_gnt_w[0]), 32'd1);
    chk("rel_if_gnt", 32'(if_gnt_w[0]), 32'd0);
    chk("rel_mem_we", 32'(mem_we_w[0]), 32'd1);

    tick(); if_req = 1'b0; dm_req = 1'b0; #2;
    chk("idle_mem_en",    32'(mem_en_w[0]),    32'd0);
    chk("idle_mem_be",    32'(mem_be_w[0]),    32'd0);
    chk("idle_dm_rvalid", 32'(dm_rvalid_w[0]), 32'd0);

    // Single fetch from 0x40.
    tick(); if_req = 1'b1; if_addr = 32'h0000_0040; #2;
    chk("fetch_if_gnt",   32'(if_gnt_w[0]),   32'd1);
    chk("fetch_mem_addr", mem_addr_w[0],      32'h0000_0040);
    chk("fetch_mem_we",   32'(mem_we_w[0]),   32'd0);
    chk("fetch_mem_be",   32'(mem_be_w[0]),   32'hF);
    chk("fetch_stall_if", 32'(stall_if_w[0]), 32'd0);
    tick(); if_req = 1'b0; if_addr = 32'h0000_0999; mem_rdata = 32'h0050_0093; #2;
    chk("fetch_if_rvalid",  32'(if_rvalid_w[0]), 32'd1);
    chk("fetch_if_rdata",   if_rdata_w[0],       32'h0050_0093);
    chk("fetch_dm_rvalid",  32'(dm_rvalid_w[0]), 32'd0);
    chk("fetch_l2_early",   32'(if_rvalid_w[1]), 32'd0);
    tick(); #2;
    chk("fetch_l1_done",    32'(if_rvalid_w[0]), 32'd0);
    chk("fetch_l2_rvalid",  32'(if_rvalid_w[1]), 32'd1);
    tick(); tick(); mem_rdata = 32'h0;

    // Conflict: both held with DM stores, IF fetching 0x80.
    tick(); if_req = 1'b1; if_addr = 32'h0000_0080;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0300;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int c = 0; c < 4; c++) begin
      if (c != 0) tick();
      #2;
      chk("rr_dm_gnt", 32'(dm_gnt_w[0]), (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_if_gnt", 32'(if_gnt_w[0]), (c % 2 == 0) ? 32'd0 : 32'd1);
    end
`else
    for (int c = 0; c < 3; c++) begin
      if (c != 0) tick();
      #2;
      chk("starve_dm_gnt",   32'(dm_gnt_w[0]),   32'd1);
      chk("starve_if_gnt",   32'(if_gnt_w[0]),   32'd0);
      chk("starve_stall_if", 32'(stall_if_w[0]), 32'd1);
      chk("starve_mem_addr", mem_addr_w[0],      32'h0000_0300);
    end
    tick(); #2;
    chk("starve4_if_gnt",    32'(if_gnt_w[0]),    32'd1);
    chk("starve4_dm_gnt",    32'(dm_gnt_w[0]),    32'd0);
    chk("starve4_mem_addr",  mem_addr_w[0],       32'h0000_0080);
    chk("starve4_stall_mem", 32'(stall_mem_w[0]), 32'd1);
    tick(); #2;
    chk("starve5_dm_gnt",    32'(dm_gnt_w[0]),    32'd1);
`endif
    tick(); if_req = 1'b0; dm_req = 1'b0;
    tick(); tick(); tick();

    // Store then load on the latency-2 instance.
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'hF; dm_addr = 32'h0000_0100;
    dm_wdata = 32'hDEAD_BEEF; #2;
    chk("st_dm_gnt",    32'(dm_gnt_w[1]),    32'd1);
    chk("st_mem_we",    32'(mem_we_w[1]),    32'd1);
    chk("st_mem_wdata", mem_wdata_w[1],      32'hDEAD_BEEF);
    chk("st_mem_addr",  mem_addr_w[1],       32'h0000_0100);
    chk("st_stall_mem", 32'(stall_mem_w[1]), 32'd0);
    tick(); dm_we = 1'b0; dm_wdata = 32'h0; #2;
    chk("ld_dm_gnt",    32'(dm_gnt_w[1]),    32'd1);
    chk("ld_mem_we",    32'(mem_we_w[1]),    32'd0);
    tick(); dm_req = 1'b0; #2;
    chk("ld_wait_stall",  32'(stall_mem_w[1]), 32'd1);
    chk("ld_wait_rvalid", 32'(dm_rvalid_w[1]), 32'd0);
    chk("ld_wait_mem_we", 32'(mem_we_w[1]),    32'd0);
    tick(); mem_rdata = 32'hDEAD_BEEF; #2;
    chk("ld_dm_rvalid", 32'(dm_rvalid_w[1]), 32'd1);
    chk("ld_dm_rdata",  dm_rdata_w[1],       32'hDEAD_BEEF);
    chk("ld_if_rvalid", 32'(if_rvalid_w[1]), 32'd0);
    tick(); mem_rdata = 32'h0; #2;
    chk("ld_done_stall",  32'(stall_mem_w[1]), 32'd0);
    chk("ld_done_rvalid", 32'(dm_rvalid_w[1]), 32'd0);
    tick(); tick(); tick();

    // Store grant and load response in the same cycle (latency 1).
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0104; #2;
    chk("ovl_ld_gnt", 32'(dm_gnt_w[0]), 32'd1);
    tick(); dm_we = 1'b1; dm_wdata = 32'hCAFE_F00D; mem_rdata = 32'h1234_5678; #2;
    chk("ovl_st_gnt",    32'(dm_gnt_w[0]),    32'd1);
    chk("ovl_st_we",     32'(mem_we_w[0]),    32'd1);
    chk("ovl_st_wdata",  mem_wdata_w[0],      32'hCAFE_F00D);
    chk("ovl_ld_rvalid", 32'(dm_rvalid_w[0]), 32'd1);
    chk("ovl_ld_rdata",  dm_rdata_w[0],       32'h1234_5678);
    tick(); dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'h0;
    tick(); tick(); tick(); tick();

    // Mid-flight reset on the latency-3 instance: the fetch must vanish.
    if_req = 1'b1; if_addr = 32'h0000_0044; #2;
    chk("mfr_if_gnt", 32'(if_gnt_w[2]), 32'd1);
    tick(); if_req = 1'b0; rst = 1'b1; mem_rdata = 32'hAAAA_5555; #2;
    chk("mfr_rst_gnt",    32'(if_gnt_w[2]),    32'd0);
    chk("mfr_rst_rvalid", 32'(if_rvalid_w[2]), 32'd0);
    tick(); rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk("mfr_no_rvalid", 32'(if_rvalid_w[2]), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
